// File: rtl/pipe_bypass_unit.sv
// Operand forwarding and load-use interlock for the ID stage of the in-order pipeline.
// A shadow pipeline of producer tags tracks in-flight writers; the youngest matching producer feeds each read port.
module pipe_bypass_unit #(
    parameter int NSTG = 3,
    parameter int NRP  = 2,
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CW   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic                id_we,
    input  logic [AW-1:0]       id_dest,
    input  logic [NSTG-1:0]     stg_allowin,
    input  logic [NSTG-1:0]     stg_ready_go,
    input  logic [NSTG-1:0]     stg_flush,
    input  logic [NSTG*DW-1:0]  stg_data,
    input  logic [NSTG-1:0]     stg_data_ok,
    input  logic [NRP-1:0]      rp_used,
    input  logic [NRP*AW-1:0]   rp_addr,
    input  logic [NRP*DW-1:0]   rf_rdata,
    output logic [NRP*DW-1:0]   rp_data,
    output logic                id_stall,
    output logic [NSTG-1:0]     stg_valid,
    output logic [CW-1:0]       cnt_stall,
    output logic [CW-1:0]       cnt_fwd
);

    logic [NSTG-1:0] r_valid;
    logic [NSTG-1:0] r_we;
    logic [AW-1:0]   r_dest [NSTG];
    logic [CW-1:0]   r_cnt_stall;
    logic [CW-1:0]   r_cnt_fwd;

    logic [NRP-1:0]  w_hit_any;
    logic [NRP-1:0]  w_win_ok;
    logic [NSTG-1:0] w_adv;
    logic            w_id_go;
    logic            w_fwd_any;
    logic            w_unused_last_ready_go;

    // The last stage is the regfile write stage; nothing downstream consumes its ready_go.
    assign w_unused_last_ready_go = stg_ready_go[NSTG-1];

    assign w_id_go   = id_valid & ~id_stall;
    assign w_fwd_any = |w_hit_any;

    // w_adv[i] is "stage i-1 hands a valid instruction to stage i"; bit 0 is the ID issue.
    always_comb begin
        w_adv    = '0;
        w_adv[0] = w_id_go;
        for (int i = 1; i < NSTG; i++) begin
            w_adv[i] = r_valid[i-1] & stg_ready_go[i-1];
        end
    end

    // NOTE: every output of this block gets a default before the loops, so no path leaves a latch.
    always_comb begin
        w_hit_any = '0;
        w_win_ok  = '0;
        rp_data   = rf_rdata;
        for (int p = 0; p < NRP; p++) begin
            // Scan oldest to youngest so the youngest hit is the last (winning) assignment.
            for (int i = NSTG - 1; i >= 0; i--) begin
                if (rp_used[p] && (rp_addr[p*AW +: AW] != '0) && r_valid[i] && r_we[i]
                    && (r_dest[i] == rp_addr[p*AW +: AW])) begin
                    w_hit_any[p]          = 1'b1;
                    w_win_ok[p]           = stg_data_ok[i];
                    rp_data[p*DW +: DW]   = stg_data[i*DW +: DW];
                end
            end
        end
    end

    assign id_stall = id_valid & |(w_hit_any & ~w_win_ok);

    // NOTE: state updates use non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_we    <= '0;
            for (int i = 0; i < NSTG; i++) begin
                r_dest[i] <= '0;
            end
        end else begin
            if (stg_flush[0]) begin
                r_valid[0] <= 1'b0;
            end else if (stg_allowin[0]) begin
                r_valid[0] <= w_adv[0];
            end
            if (stg_allowin[0] && w_adv[0]) begin
                r_we[0]   <= id_we;
                r_dest[0] <= id_dest;
            end
            for (int i = 1; i < NSTG; i++) begin
                if (stg_flush[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (stg_allowin[i]) begin
                    r_valid[i] <= w_adv[i];
                end
                if (stg_allowin[i] && w_adv[i]) begin
                    r_we[i]   <= r_we[i-1];
                    r_dest[i] <= r_dest[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_stall <= '0;
            r_cnt_fwd   <= '0;
        end else begin
            if (id_stall && id_valid && (r_cnt_stall != '1)) begin
                r_cnt_stall <= r_cnt_stall + CW'(1);
            end
            if (w_fwd_any && (r_cnt_fwd != '1)) begin
                r_cnt_fwd <= r_cnt_fwd + CW'(1);
            end
        end
    end

    assign stg_valid = r_valid;
    assign cnt_stall = r_cnt_stall;
    assign cnt_fwd   = r_cnt_fwd;

endmodule

// File: tb/tb_pipe_bypass_unit.sv
// Bench for pipe_bypass_unit: directed scenarios then random traffic, all checked against a
// behavioural model of the in-flight producer list.
module tb_pipe_bypass_unit;

    localparam int NSTG = 3;
    localparam int NRP  = 2;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                id_valid;
    logic                id_we;
    logic [AW-1:0]       id_dest;
    logic [NSTG-1:0]     stg_allowin;
    logic [NSTG-1:0]     stg_ready_go;
    logic [NSTG-1:0]     stg_flush;
    logic [NSTG*DW-1:0]  stg_data;
    logic [NSTG-1:0]     stg_data_ok;
    logic [NRP-1:0]      rp_used;
    logic [NRP*AW-1:0]   rp_addr;
    logic [NRP*DW-1:0]   rf_rdata;
    logic [NRP*DW-1:0]   rp_data;
    logic                id_stall;
    logic [NSTG-1:0]     stg_valid;
    logic [CW-1:0]       cnt_stall;
    logic [CW-1:0]       cnt_fwd;

    always #5 clk = ~clk;

    pipe_bypass_unit #(.NSTG(NSTG), .NRP(NRP), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_we        (id_we),
        .id_dest      (id_dest),
        .stg_allowin  (stg_allowin),
        .stg_ready_go (stg_ready_go),
        .stg_flush    (stg_flush),
        .stg_data     (stg_data),
        .stg_data_ok  (stg_data_ok),
        .rp_used      (rp_used),
        .rp_addr      (rp_addr),
        .rf_rdata     (rf_rdata),
        .rp_data      (rp_data),
        .id_stall     (id_stall),
        .stg_valid    (stg_valid),
        .cnt_stall    (cnt_stall),
        .cnt_fwd      (cnt_fwd)
    );

    // Model: list of in-flight producers, index 0 = youngest (EXE).
    bit          m_valid [NSTG];
    bit          m_we    [NSTG];
    int          m_dest  [NSTG];
    int          m_cnt_stall;
    int          m_cnt_fwd;
    bit          m_stall;
    bit          m_fwd;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight producer of the register read on port p, or -1 for the regfile.
    function automatic int producer_of(int p);
        int addr;
        addr = int'(rp_addr[p*AW +: AW]);
        if (!rp_used[p] || addr == 0) return -1;
        for (int i = 0; i < NSTG; i++) begin
            if (m_valid[i] && m_we[i] && m_dest[i] == addr) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        bit           any_wait;
        int           w;
        logic [DW-1:0] exp;
        logic [NSTG-1:0] ev;
        #1;
        any_wait = 1'b0;
        m_fwd    = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            w = producer_of(p);
            if (w < 0) begin
                exp = rf_rdata[p*DW +: DW];
            end else begin
                exp   = stg_data[w*DW +: DW];
                m_fwd = 1'b1;
                if (!stg_data_ok[w]) any_wait = 1'b1;
            end
            check($sformatf("rp_data%0d", p), 64'(rp_data[p*DW +: DW]), 64'(exp));
        end
        m_stall = id_valid & any_wait;
        for (int i = 0; i < NSTG; i++) ev[i] = m_valid[i];
        check("id_stall", 64'(id_stall), 64'(m_stall));
        check("stg_valid", 64'(stg_valid), 64'(ev));
        check("cnt_stall", 64'(cnt_stall), 64'(m_cnt_stall));
        check("cnt_fwd", 64'(cnt_fwd), 64'(m_cnt_fwd));
    endtask

    // Advance the model with the inputs present before the edge, then clock the DUT.
    task automatic tick();
        bit nv [NSTG];
        bit nw [NSTG];
        int nd [NSTG];
        bit moving;
        for (int i = 0; i < NSTG; i++) begin
            nv[i] = m_valid[i]; nw[i] = m_we[i]; nd[i] = m_dest[i];
        end
        if (reset) begin
            for (int i = 0; i < NSTG; i++) begin
                nv[i] = 1'b0; nw[i] = 1'b0; nd[i] = 0;
            end
            m_cnt_stall = 0;
            m_cnt_fwd   = 0;
        end else begin
            moving = id_valid && !m_stall;
            if (stg_flush[0]) nv[0] = 1'b0;
            else if (stg_allowin[0]) nv[0] = moving;
            if (stg_allowin[0] && moving) begin
                nw[0] = id_we; nd[0] = int'(id_dest);
            end
            for (int i = 1; i < NSTG; i++) begin
                moving = m_valid[i-1] && stg_ready_go[i-1];
                if (stg_flush[i]) nv[i] = 1'b0;
                else if (stg_allowin[i]) nv[i] = moving;
                if (stg_allowin[i] && moving) begin
                    nw[i] = m_we[i-1]; nd[i] = m_dest[i-1];
                end
            end
            if (m_stall && m_cnt_stall < CMAX) m_cnt_stall++;
            if (m_fwd && m_cnt_fwd < CMAX) m_cnt_fwd++;
        end
        @(posedge clk);
        for (int i = 0; i < NSTG; i++) begin
            m_valid[i] = nv[i]; m_we[i] = nw[i]; m_dest[i] = nd[i];
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset        = 1'b0;
        id_valid     = 1'b0;
        id_we        = 1'b0;
        id_dest      = '0;
        stg_allowin  = '1;
        stg_ready_go = '1;
        stg_flush    = '0;
        stg_data_ok  = '1;
        rp_used      = '0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int k = 0; k < NSTG; k++) begin
            check_outputs();
            tick();
        end
    endtask

    task automatic issue(input logic we, input int dest);
        id_valid = 1'b1;
        id_we    = we;
        id_dest  = AW'(dest);
        rp_used  = '0;
        check_outputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        reset    = 1'b1;
        stg_data = '0;
        rp_addr  = '0;
        rf_rdata = {32'h2222_2222, 32'h1111_1111};
        tick();
        tick();
        reset = 1'b0;
        check_outputs();
        check("reset_rp_data0", 64'(rp_data[DW-1:0]), 64'h1111_1111);
        check("reset_stall", 64'(id_stall), 64'h0);

        // Back-to-back ALU dependency on r5.
        issue(1'b1, 5);
        id_we    = 1'b0;
        rp_used  = 2'b01;
        rp_addr  = {5'd0, 5'd5};
        stg_data = {32'h0, 32'h0, 32'h11};
        stg_data_ok = '1;
        check_outputs();
        check("alu_fwd_data", 64'(rp_data[DW-1:0]), 64'h11);
        check("alu_fwd_stall", 64'(id_stall), 64'h0);
        tick();
        check("alu_cnt_fwd", 64'(cnt_fwd), 64'h1);
        drain();

        // Load-use on r7: one stall cycle, then forward from stage 1.
        issue(1'b1, 7);
        id_we       = 1'b0;
        rp_used     = 2'b01;
        rp_addr     = {5'd0, 5'd7};
        stg_data_ok = 3'b110;
        check_outputs();
        check("load_use_stall", 64'(id_stall), 64'h1);
        tick();
        stg_data_ok = 3'b111;
        stg_data    = {32'h0, 32'h0000_CAFE, 32'h0};
        check_outputs();
        check("load_use_data", 64'(rp_data[DW-1:0]), 64'hCAFE);
        check("load_use_nostall", 64'(id_stall), 64'h0);
        check("load_use_cnt_stall", 64'(cnt_stall), 64'h1);
        tick();
        drain();

        // Youngest wins: r3 in stage 2 and stage 0.
        issue(1'b1, 3);
        issue(1'b0, 3);
        issue(1'b1, 3);
        id_we       = 1'b0;
        rp_used     = 2'b10;
        rp_addr     = {5'd3, 5'd0};
        stg_data    = {32'hAA, 32'h77, 32'hBB};
        stg_data_ok = '1;
        check_outputs();
        check("youngest_data", 64'(rp_data[2*DW-1:DW]), 64'hBB);
        stg_data_ok = 3'b110;
        check_outputs();
        check("youngest_not_ok_stall", 64'(id_stall), 64'h1);
        tick();
        drain();

        // r0 writer and an unused port whose address matches a live producer.
        issue(1'b1, 12);
        issue(1'b1, 0);
        id_we       = 1'b0;
        rp_used     = 2'b01;
        rp_addr     = {5'd12, 5'd0};
        stg_data    = {32'h0, 32'h66, 32'h55};
        stg_data_ok = '0;
        rf_rdata    = {32'hBEEF_0001, 32'hBEEF_0000};
        check_outputs();
        check("r0_passthru", 64'(rp_data[DW-1:0]), 64'hBEEF_0000);
        check("unused_passthru", 64'(rp_data[2*DW-1:DW]), 64'hBEEF_0001);
        check("r0_unused_nostall", 64'(id_stall), 64'h0);
        tick();
        drain();

        // Branch kill of the r9 producer in stage 0.
        issue(1'b1, 9);
        stg_flush    = 3'b001;
        stg_ready_go = 3'b110;
        check_outputs();
        tick();
        stg_flush    = '0;
        stg_ready_go = '1;
        rp_used      = 2'b01;
        rp_addr      = {5'd0, 5'd9};
        rf_rdata     = {32'h0, 32'h9999_0000};
        check_outputs();
        check("flush_valid", 64'(stg_valid), 64'h0);
        check("flush_passthru", 64'(rp_data[DW-1:0]), 64'h9999_0000);
        tick();
        drain();

        // Long stall with the pipeline frozen until cnt_stall saturates.
        issue(1'b1, 7);
        id_we       = 1'b0;
        rp_used     = 2'b01;
        rp_addr     = {5'd0, 5'd7};
        stg_allowin = '0;
        stg_data_ok = '0;
        for (int k = 0; k < CMAX + 8; k++) begin
            check_outputs();
            tick();
        end
        check("sat_cnt_stall", 64'(cnt_stall), 64'(CMAX));
        reset = 1'b1;
        check_outputs();
        tick();
        reset       = 1'b0;
        stg_allowin = '1;
        stg_data_ok = '1;
        check_outputs();
        check("reset_valid", 64'(stg_valid), 64'h0);
        check("reset_cnt_stall", 64'(cnt_stall), 64'h0);
        check("reset_cnt_fwd", 64'(cnt_fwd), 64'h0);
        check("reset_no_stale", 64'(rp_data[DW-1:0]), 64'(rf_rdata[DW-1:0]));
        tick();

        // Random traffic on a small register range so hits, flushes and back-pressure collide.
        for (int k = 0; k < 600; k++) begin
            reset        = ($urandom_range(0, 63) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_we        = $urandom_range(0, 1) == 1;
            id_dest      = AW'($urandom_range(0, 3));
            for (int i = 0; i < NSTG; i++) begin
                stg_allowin[i]  = ($urandom_range(0, 7) != 0);
                stg_ready_go[i] = ($urandom_range(0, 7) != 0);
                stg_flush[i]    = ($urandom_range(0, 15) == 0);
                stg_data_ok[i]  = ($urandom_range(0, 3) != 0);
                stg_data[i*DW +: DW] = $urandom;
            end
            for (int p = 0; p < NRP; p++) begin
                rp_used[p]           = $urandom_range(0, 1) == 1;
                rp_addr[p*AW +: AW]  = AW'($urandom_range(0, 3));
                rf_rdata[p*DW +: DW] = $urandom;
            end
            check_outputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_bypass_unit.md
Name: pipe_bypass_unit

Overview:
- Parametrised forwarding and interlock unit for the in-order scalar pipeline; generalises the fixed EXE/MEM/WB, two-operand, load-use-only bypass logic.
- Keeps its own shadow pipeline of producer tags (valid, we, dest) that advances with the datapath's valid/allowin handshake.
- For each ID-stage read port, selects the youngest in-flight producer's data or the register-file data, and raises a stall when that producer's result is not ready yet.
- Sits beside the ID stage, between the regfile read ports and the operand muxes; includes saturating stall/forward event counters.

Parameters:
- NSTG, 3, number of tracked stages after ID (0 = EXE, NSTG-1 = WB).
- NRP, 2, number of ID read ports.
- DW, 32, data width.
- AW, 5, architectural register index width; index 0 is hardwired zero.
- CW, 32, event counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction (ID_to_EXE_valid before the stall term)
- id_we  in  1  ID instruction writes the register file
- id_dest  in  AW  ID destination register
- stg_allowin  in  NSTG  per-stage allowin from the datapath
- stg_ready_go  in  NSTG  per-stage ready_go from the datapath
- stg_flush  in  NSTG  per-stage kill; the stage's valid is cleared next cycle
- stg_data  in  NSTG*DW  per-stage result, stage i in bits [i*DW +: DW]
- stg_data_ok  in  NSTG  stage i result is final this cycle (0 for a load in EXE, or a multi-cycle op)
- rp_used  in  NRP  port p is read by the ID instruction
- rp_addr  in  NRP*AW  port p register index
- rf_rdata  in  NRP*DW  regfile read data for port p
- rp_data  out  NRP*DW  bypassed operand for port p
- id_stall  out  1  ID must hold (combined into the ID ready_go by the datapath)
- stg_valid  out  NSTG  shadow valid bits, for debug
- cnt_stall  out  CW  cycles with id_stall=1 and id_valid=1
- cnt_fwd  out  CW  cycles in which at least one used port took bypass data

Behaviour:
- Reset: all shadow valid bits = 0; tags (we, dest) = 0; counters = 0.
  - rp_data then equals rf_rdata; id_stall = 0.
- Stage 0 update on a clk edge:
  - if reset or stg_flush[0]: valid0 <= 0;
  - else if stg_allowin[0]: valid0 <= id_valid & ~id_stall.
  - Tags load when id_valid & ~id_stall & stg_allowin[0].
- Stage i>0 update:
  - if reset or stg_flush[i]: valid_i <= 0;
  - else if stg_allowin[i]: valid_i <= valid_{i-1} & stg_ready_go[i-1].
  - Tags copy from i-1 under the same condition with valid_{i-1} = 1.
  - Stage NSTG-1 retires silently; it is the regfile write stage.
- Flush priority: flush beats load. A flush and a load on the same stage in the same cycle leaves valid = 0.
- Hit definition: hit[p][i] = rp_used[p] & (addr != 0) & valid_i & we_i & (dest_i == addr).
- Priority: the lowest stage index with a hit (the youngest producer) wins; older hits are ignored.
- Operand select: rp_data[p] = stg_data[i] of the winning stage, else rf_rdata[p]. This path is purely combinational, zero latency.
- Stall: id_stall = id_valid & OR over p of (winning hit exists & ~stg_data_ok[win]).
  - A not-ready older stage that is shadowed by a ready younger hit does not stall.
- Stage NSTG-1 bypass is required: the regfile has no internal write-through.
- Counters: +1 per qualifying cycle, saturating at all-ones with no wrap. cnt_fwd counts at most once per cycle.
- Stall while downstream is blocked: stage 0 keeps its contents while stg_allowin[0] = 0. A stalled ID never inserts a duplicate.
- Reset mid-stream: all in-flight tags are dropped in one cycle, and no stale forwarding occurs on the next cycle.

Test Plan:
- Back-to-back ALU dependency: write r5 = 0x11, then read r5 on port 0 with stg_data_ok[0] = 1. Expect rp_data0 = 0x11 from stage 0, id_stall = 0, cnt_fwd = 1.
- Load-use: load to r7 sits in stage 0 with data_ok[0] = 0, consumer reads r7. Expect id_stall = 1 for one cycle. Next cycle the load is in stage 1 with data_ok = 1 and data 0xCAFE; expect rp_data = 0xCAFE, stall = 0, cnt_stall = 1.
- Youngest wins: r3 is written in stage 2 (0xAA) and stage 0 (0xBB), both ok. Expect rp_data = 0xBB. With stage 0 not ok, expect stall = 1 even though stage 2 is ready.
- r0 and unused ports: stage 0 writes r0 = 0x55 and the port reads r0; separately, rp_used = 0 with a matching address. Expect rf_rdata passthrough and no stall in both cases.
- Flush: branch kill of stage 0 holding r9 (stg_flush[0] = 1). Next cycle stg_valid[0] = 0 and reads of r9 return rf_rdata.
- Counter saturation and reset: preload, or force a long stall until cnt_stall = all-ones; it holds. Assert reset: all counters and stg_valid = 0 on the next edge.
